// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store unit between EX/MEM and MEM/WB.
// One RAM byte per ack, little-endian; holds the pipeline until the last byte.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_we,
   input  logic [4:0]  in_waddr,
   input  logic [31:0] in_result,
   output logic        stall_req,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   input  logic        ram_ack,
   output logic        wb_we,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata
);
   localparam logic [7:0] OP_LB  = 8'h20;
   localparam logic [7:0] OP_LH  = 8'h21;
   localparam logic [7:0] OP_LW  = 8'h22;
   localparam logic [7:0] OP_LBU = 8'h23;
   localparam logic [7:0] OP_LHU = 8'h24;
   localparam logic [7:0] OP_SB  = 8'h28;
   localparam logic [7:0] OP_SH  = 8'h29;
   localparam logic [7:0] OP_SW  = 8'h2A;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t      r_state;
   logic [1:0]  r_k;
   logic [23:0] r_buf;

   logic        w_load;
   logic        w_store;
   logic        w_signed;
   logic        w_mem;
   logic [1:0]  w_last;
   logic [1:0]  w_k;
   logic        w_final;
   logic [31:0] w_ldata;
   logic [31:0] w_wsh;

   always_comb begin
      w_load   = 1'b0;
      w_store  = 1'b0;
      w_signed = 1'b0;
      w_last   = 2'd0;
      case (in_op)
         OP_LB:  begin w_load = 1'b1; w_signed = 1'b1; end
         OP_LH:  begin w_load = 1'b1; w_signed = 1'b1; w_last = 2'd1; end
         OP_LW:  begin w_load = 1'b1; w_last = 2'd3; end
         OP_LBU: w_load = 1'b1;
         OP_LHU: begin w_load = 1'b1; w_last = 2'd1; end
         OP_SB:  w_store = 1'b1;
         OP_SH:  begin w_store = 1'b1; w_last = 2'd1; end
         OP_SW:  begin w_store = 1'b1; w_last = 2'd3; end
         default: ;
      endcase
   end

   assign w_mem   = w_load | w_store;
   // IDLE always means byte 0, whatever r_k holds
   assign w_k     = (r_state == S_IDLE) ? 2'd0 : r_k;
   assign w_final = w_mem & ram_ack & (w_k == w_last);
   assign w_wsh   = in_wdata >> {w_k, 3'b000};

   always_comb begin
      case (w_last)
         2'd0:    w_ldata = {{24{w_signed & ram_rdata[7]}}, ram_rdata};
         2'd1:    w_ldata = {{16{w_signed & ram_rdata[7]}},
                             ram_rdata, r_buf[7:0]};
         default: w_ldata = {ram_rdata, r_buf};
      endcase
   end

   always_comb begin
      stall_req = 1'b0;
      ram_req   = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 32'd0;
      ram_wdata = 8'd0;
      wb_we     = 1'b0;
      wb_waddr  = 5'd0;
      wb_wdata  = 32'd0;
      if (!rst) begin
         if (w_mem) begin
            ram_req   = 1'b1;
            ram_addr  = in_addr + {30'd0, w_k};
            ram_we    = w_store;
            ram_wdata = w_store ? w_wsh[7:0] : 8'd0;
            stall_req = ~w_final;
            if (w_final && w_load) begin
               wb_we    = in_we;
               wb_waddr = in_waddr;
               wb_wdata = w_ldata;
            end
         end else begin
            wb_we    = in_we;
            wb_waddr = in_waddr;
            wb_wdata = in_result;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
         r_buf   <= 24'd0;
      end else if (w_mem && ram_ack) begin
         if (w_k == w_last) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
         end else begin
            r_state <= S_ACCESS;
            r_k     <= w_k + 2'd1;
            if (w_load) begin
               case (w_k)
                  2'd0:    r_buf[7:0]   <= ram_rdata;
                  2'd1:    r_buf[15:8]  <= ram_rdata;
                  default: r_buf[23:16] <= ram_rdata;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random load/store/pass-through traffic against a
// byte-array memory model, plus directed literal cases.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_we;
   logic [4:0]  in_waddr;
   logic [31:0] in_result;
   logic        stall_req;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        ram_ack;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_we(in_we), .in_waddr(in_waddr), .in_result(in_result),
      .stall_req(stall_req), .ram_req(ram_req), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [logic [31:0]];

   logic        e_valid = 1'b0;
   logic        e_full;
   logic        e_stall, e_req, e_we, e_wbwe;
   logic [31:0] e_addr, e_wbwd;
   logic [7:0]  e_wd;
   logic [4:0]  e_wbwa;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (e_valid) begin
         chk("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
         chk("ram_req", {31'd0, ram_req}, {31'd0, e_req});
         chk("wb_we", {31'd0, wb_we}, {31'd0, e_wbwe});
         chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e_wbwa});
         chk("wb_wdata", wb_wdata, e_wbwd);
         if (e_full) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
            chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, e_wd});
         end
      end
   end

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic int nb(input logic [7:0] op);
      case (op)
         8'h20, 8'h23, 8'h28: return 1;
         8'h21, 8'h24, 8'h29: return 2;
         8'h22, 8'h2A:        return 4;
         default:             return 0;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input logic [7:0] op,
                                            input logic [31:0] a);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < nb(op); i++)
         v = v | ({24'd0, rd(a + i)} << (8 * i));
      if (op == 8'h20 && v[7])  v = v | 32'hFFFFFF00;
      if (op == 8'h21 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   task automatic set_zero_exp();
      e_full = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
      e_addr = 32'd0; e_wd = 8'd0;
      e_wbwe = 1'b0; e_wbwa = 5'd0; e_wbwd = 32'd0;
   endtask

   task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we,
                         input logic [4:0] wa, input logic [31:0] res,
                         input int wmin, input int wmax, input int rst_at,
                         input logic spur,
                         output logic [31:0] seen, output int ncyc);
      int  n, w;
      logic ack, fin, st;
      n = nb(op);
      st = (op >= 8'h28);
      seen = 32'd0;
      ncyc = 0;
      for (int j = 0; j < ((n == 0) ? 1 : n); j++) begin
         w = (n == 0) ? 0 : int'($urandom_range(wmin, wmax));
         for (int c = 0; c <= w; c++) begin
            @(posedge clk); #1;
            ncyc++;
            rst = 1'b0;
            in_op = op; in_addr = addr; in_wdata = wd;
            in_we = we; in_waddr = wa; in_result = res;
            ram_rdata = 8'($urandom);
            if (n > 0 && rst_at == j && c == 0) begin
               rst = 1'b1;
               ram_ack = 1'b0;
               set_zero_exp();
               e_valid = 1'b1;
               return;
            end
            if (n == 0) begin
               ram_ack = spur;
               e_full = 1'b0; e_stall = 1'b0; e_req = 1'b0;
               e_wbwe = we; e_wbwa = wa; e_wbwd = res;
               e_valid = 1'b1;
               #1 seen = wb_wdata;
               return;
            end
            ack = (c == w);
            fin = ack && (j == n - 1);
            ram_ack = ack;
            if (ack && !st) ram_rdata = rd(addr + j);
            e_full = 1'b1;
            e_req = 1'b1;
            e_addr = addr + j;
            e_we = st;
            e_wd = st ? wd[8*j +: 8] : 8'd0;
            e_stall = !fin;
            if (fin && !st) begin
               e_wbwe = we; e_wbwa = wa; e_wbwd = load_val(op, addr);
            end else begin
               e_wbwe = 1'b0; e_wbwa = 5'd0; e_wbwd = 32'd0;
            end
            e_valid = 1'b1;
            #1 seen = wb_wdata;
            if (ack && st) mem[addr + j] = wd[8*j +: 8];
            if (fin) return;
         end
      end
   endtask

   logic [31:0] seen;
   int          ncyc;

   initial begin
      logic [7:0]  ops [8];
      logic [7:0]  op;
      logic [31:0] a;
      int          ra;
      ops = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h28, 8'h29, 8'h2A};
      rst = 1'b1;
      in_op = 8'h00; in_addr = 32'd0; in_wdata = 32'd0;
      in_we = 1'b0; in_waddr = 5'd0; in_result = 32'd0;
      ram_rdata = 8'd0; ram_ack = 1'b0;

      // reset: outputs held at zero even with a live load presented
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         rst = 1'b1;
         in_op = 8'h22; in_addr = 32'h100; in_we = 1'b1;
         in_waddr = 5'd7; in_result = 32'hDEAD;
         set_zero_exp();
         e_valid = 1'b1;
      end

      mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
      mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
      mem[32'h200] = 8'h80;

      run_op(8'h01, 0, 0, 1'b1, 5'd5, 32'h1234, 0, 0, -1, 1'b0,
             seen, ncyc);
      chk("pass_lit", seen, 32'h1234);

      run_op(8'h22, 32'h100, 0, 1'b1, 5'd3, 0, 0, 0, -1, 1'b0,
             seen, ncyc);
      chk("lw_lit", seen, 32'h44332211);
      chk("lw_cycles", ncyc, 4);

      run_op(8'h20, 32'h200, 0, 1'b1, 5'd4, 0, 2, 2, -1, 1'b0,
             seen, ncyc);
      chk("lb_lit", seen, 32'hFFFFFF80);
      chk("lb_cycles", ncyc, 3);
      run_op(8'h23, 32'h200, 0, 1'b1, 5'd4, 0, 2, 2, -1, 1'b0,
             seen, ncyc);
      chk("lbu_lit", seen, 32'h00000080);

      run_op(8'h29, 32'hFFFFFFFF, 32'hAABBCCDD, 1'b1, 5'd9, 0, 0, 0,
             -1, 1'b0, seen, ncyc);
      chk("sh_wb", seen, 32'd0);
      run_op(8'h24, 32'hFFFFFFFF, 0, 1'b1, 5'd9, 0, 0, 1, -1, 1'b0,
             seen, ncyc);
      chk("lhu_wrap_lit", seen, 32'h0000CCDD);

      run_op(8'h22, 32'h100, 0, 1'b1, 5'd3, 0, 0, 1, 2, 1'b0,
             seen, ncyc);
      run_op(8'h21, 32'h100, 0, 1'b1, 5'd6, 0, 0, 0, -1, 1'b0,
             seen, ncyc);
      chk("lh_after_rst", seen, 32'h00002211);
      chk("lh_cycles", ncyc, 2);

      run_op(8'h05, 0, 0, 1'b1, 5'd1, 32'h77, 0, 0, -1, 1'b1,
             seen, ncyc);
      run_op(8'h07, 0, 0, 1'b0, 5'd2, 32'h88, 0, 0, -1, 1'b1,
             seen, ncyc);
      run_op(8'h22, 32'h100, 0, 1'b1, 5'd3, 0, 0, 0, -1, 1'b0,
             seen, ncyc);
      chk("lw_after_spur", seen, 32'h44332211);

      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 31));
         else op = ops[$urandom_range(0, 7)];
         case ($urandom_range(0, 2))
            0:       a = 32'hFFFFFFFC + $urandom_range(0, 3);
            1:       a = 32'h300 + $urandom_range(0, 15);
            default: a = $urandom;
         endcase
         ra = ($urandom_range(0, 19) == 0) ?
              int'($urandom_range(0, 3)) : -1;
         run_op(op, a, $urandom, 1'($urandom), 5'($urandom), $urandom,
                0, 3, ra, 1'($urandom), seen, ncyc);
      end

      @(posedge clk); #1;
      e_valid = 1'b0;
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It takes the operation, effective address, store data and ALU result from EX/MEM. It performs loads and stores over a byte-wide request/acknowledge RAM bus, one byte per transaction, little-endian. It holds the pipeline through stall_req until the access completes, then presents the write-back triple to MEM/WB.

## Interface
- OP_LB, 8'h20, load byte, sign-extend
- OP_LH, 8'h21, load halfword, sign-extend
- OP_LW, 8'h22, load word
- OP_LBU, 8'h23, load byte, zero-extend
- OP_LHU, 8'h24, load halfword, zero-extend
- OP_SB / OP_SH / OP_SW, 8'h28 / 8'h29 / 8'h2A, store byte / half / word
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_op  in  8  operation from EX/MEM; any non-load/store value is a pass-through op
- in_addr  in  32  effective address
- in_wdata  in  32  store data
- in_we  in  1  register write enable from EX/MEM
- in_waddr  in  5  destination register
- in_result  in  32  ALU result for pass-through ops
- stall_req  out  1  hold request to the pipeline controller
- ram_req  out  1  byte transaction request
- ram_we  out  1  1 = write, 0 = read
- ram_addr  out  32  byte address
- ram_wdata  out  8  write byte
- ram_rdata  in  8  read byte, valid when ram_ack = 1
- ram_ack  in  1  one-cycle completion pulse; may arrive in the same cycle as ram_req or any later cycle
- wb_we  out  1  write enable to MEM/WB
- wb_waddr  out  5  destination to MEM/WB
- wb_wdata  out  32  write data to MEM/WB

## Operation
- Size N: 1 for B/BU, 2 for H/HU, 4 for W.
- States: IDLE and ACCESS.
- Registered state: byte index k (2 bits, 0..N-1) and a 24-bit load buffer buf.
- Memory op present (in IDLE or ACCESS):
  - ram_req = 1; ram_addr = in_addr + k, with 32-bit wrap (0xFFFFFFFF + 1 = 0).
  - ram_we = 1 for stores; ram_wdata = in_wdata[8k+7:8k].
  - ram_we and ram_wdata are 0 for loads.
- ram_ack with k < N-1:
  - For a load, buf byte k <= ram_rdata.
  - k <= k+1; state <= ACCESS.
- ram_ack with k = N-1 (final cycle):
  - stall_req = 0.
  - Next edge: state <= IDLE, k <= 0.
- stall_req = (memory op) AND NOT (ram_ack AND k = N-1). It is combinational.
- No ram_ack: all state holds, and ram_req, ram_addr and ram_wdata stay stable.
- Inputs are stable while stall_req = 1, because the controller holds EX/MEM.
- Load data = {ram_rdata, buf bytes k-1..0}, with ram_rdata in the final byte position.
  - Sign- or zero-extended per op to 32 bits.
  - LW: bits 31:24 come from ram_rdata.
- Write-back outputs:
  - Final load cycle: wb_we = in_we, wb_waddr = in_waddr, wb_wdata = load data.
  - Final store cycle: wb_we = 0, wb_waddr = 0, wb_wdata = 0.
  - Non-final memory cycles: all wb outputs 0.
  - Pass-through op: wb_we = in_we, wb_waddr = in_waddr, wb_wdata = in_result, stall_req = 0, ram_req = 0.
- No alignment check. A misaligned access is N sequential bytes.
- ram_ack while ram_req = 0 is ignored.

## Timing
- Reset:
  - State IDLE, k = 0, buf = 0.
  - While rst = 1, ram_req, stall_req and wb_we are forced 0, and every other output is 0.
- Reset mid-access abandons the access; nothing is retried.
- Latency with zero-wait RAM (ack in the same cycle as req) is N cycles; stall_req is high for N-1 cycles.
- Each wait cycle adds one cycle to the access.
- An instruction change is seen only after the final cycle, so no back-to-back restart on the same op.
- Back-to-back memory ops: the second starts its k = 0 request in the first cycle after the previous final cycle.

## Test plan
- Pass-through: in_op = 8'h01, in_we = 1, in_waddr = 5, in_result = 32'h1234 -> same cycle wb_we = 1, wb_waddr = 5, wb_wdata = 32'h1234; stall_req = 0, ram_req = 0.
- LW at 0x100, zero-wait, RAM bytes 11 22 33 44 -> ram_addr 0x100..0x103 over 4 cycles; stall_req 1,1,1,0; final wb_wdata = 32'h44332211.
- LB vs LBU of byte 0x80, with 2 wait cycles -> ram_req held 3 cycles at constant address; wb_wdata = 32'hFFFFFF80 for LB, 32'h00000080 for LBU.
- SH with in_wdata = 32'hAABBCCDD at 0xFFFFFFFF -> writes DD to 0xFFFFFFFF, then CC to 0x00000000; wb_we = 0.
- rst asserted after byte 1 of an LW -> next cycle state IDLE, k = 0; ram_req and stall_req 0 during rst; after release, a new LH completes in 2 cycles.
- Spurious ram_ack during a pass-through op -> no state change; next LW still starts at k = 0.
